// File: rtl/alu_pkg.sv
// Shared ALU constants and entry layout used by the ALU and its downstream buffer.
package alu_pkg;

    localparam int SEL_W     = 6;
    localparam int NUM_FLAGS = 7;
    localparam int NUM_OPS   = 35;
    localparam int ALU_N     = 64;

    localparam int FLG_CARRY    = 0;
    localparam int FLG_OVERFLOW = 1;
    localparam int FLG_ZERO     = 2;
    localparam int FLG_NEGATIVE = 3;
    localparam int FLG_PARITY   = 4;
    localparam int FLG_MODULO   = 5;
    localparam int FLG_SIGN     = 6;

    typedef struct packed {
        logic [SEL_W-1:0]     sel;
        logic [ALU_N-1:0]     result;
        logic [ALU_N-1:0]     upper;
        logic [NUM_FLAGS-1:0] flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_rb_storage.sv
// Entry register array for the ALU result buffer: one write port, asynchronous read.
module alu_rb_storage #(
    parameter int W     = 141,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Cleared on reset so the head entry reads as zero while empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// In-order FIFO capturing ALU results, with sticky flags, illegal-opcode error and push counter.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [N-1:0]             in_result,
    input  logic [N-1:0]             in_upper,
    input  logic [NUM_FLAGS-1:0]     in_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_sel,
    output logic [N-1:0]             out_result,
    output logic [N-1:0]             out_upper,
    output logic [NUM_FLAGS-1:0]     out_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic [NUM_FLAGS-1:0]     sticky_flags,
    output logic                     err_illegal_sel,
    input  logic                     sticky_clr,
    output logic [31:0]              op_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = SEL_W + 2 * N + NUM_FLAGS;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          illegal;
    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign illegal   = (in_sel >= SEL_W'(NUM_OPS));

    assign wdata = {in_sel, in_result, in_upper, in_flags};
    assign {out_sel, out_result, out_upper, out_flags} = rdata;

    alu_rb_storage #(
        .W     (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // A push in the same cycle as a clear restarts accumulation from this entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags    <= '0;
            err_illegal_sel <= 1'b0;
            op_count        <= '0;
        end else begin
            if (push) begin
                sticky_flags    <= (sticky_clr ? '0 : sticky_flags) | in_flags;
                err_illegal_sel <= (!sticky_clr && err_illegal_sel) | illegal;
                op_count        <= op_count + 32'd1;
            end else if (sticky_clr) begin
                sticky_flags    <= '0;
                err_illegal_sel <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomised self-checking bench for alu_result_buffer against a queue-based reference model.
module tb_alu_result_buffer;

    localparam int N     = 64;
    localparam int DEPTH = 4;

    typedef struct {
        logic [5:0]  sel;
        logic [63:0] result;
        logic [63:0] upper;
        logic [6:0]  flags;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_sel;
    logic [63:0] in_result;
    logic [63:0] in_upper;
    logic [6:0]  in_flags;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_sel;
    logic [63:0] out_result;
    logic [63:0] out_upper;
    logic [6:0]  out_flags;
    logic [2:0]  count;
    logic [6:0]  sticky_flags;
    logic        err_illegal_sel;
    logic        sticky_clr;
    logic [31:0] op_count;

    int checks   = 0;
    int failures = 0;

    ent_t        mq[$];
    logic [6:0]  m_sticky;
    logic        m_err;
    logic [31:0] m_opc;
    bit          check_en    = 0;
    bit          preload_opc = 0;

    alu_result_buffer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_sel          (in_sel),
        .in_result       (in_result),
        .in_upper        (in_upper),
        .in_flags        (in_flags),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sel         (out_sel),
        .out_result      (out_result),
        .out_upper       (out_upper),
        .out_flags       (out_flags),
        .count           (count),
        .sticky_flags    (sticky_flags),
        .err_illegal_sel (err_illegal_sel),
        .sticky_clr      (sticky_clr),
        .op_count        (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of entries plus sticky/counter rules, updated at each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_sticky = '0;
            m_err    = 1'b0;
            m_opc    = '0;
        end else begin
            bit   acc;
            bit   deq;
            ent_t e;
            acc = in_valid && (mq.size() < DEPTH);
            deq = out_ready && (mq.size() > 0);
            if (preload_opc) m_opc = 32'hFFFF_FFFF;
            if (deq) void'(mq.pop_front());
            if (acc) begin
                e.sel = in_sel; e.result = in_result; e.upper = in_upper; e.flags = in_flags;
                mq.push_back(e);
                m_sticky = (sticky_clr ? 7'd0 : m_sticky) | in_flags;
                m_err    = (sticky_clr ? 1'b0 : m_err) | (in_sel > 6'd34);
                m_opc    = m_opc + 32'd1;
            end else if (sticky_clr) begin
                m_sticky = '0;
                m_err    = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("in_ready", in_ready, mq.size() < DEPTH);
            check("out_valid", out_valid, mq.size() > 0);
            check("count", count, mq.size());
            check("sticky_flags", sticky_flags, m_sticky);
            check("err_illegal_sel", err_illegal_sel, m_err);
            check("op_count", op_count, m_opc);
            if (mq.size() > 0) begin
                check("out_sel", out_sel, mq[0].sel);
                check("out_result", out_result, mq[0].result);
                check("out_upper", out_upper, mq[0].upper);
                check("out_flags", out_flags, mq[0].flags);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input logic [5:0] s, input logic [63:0] r,
                          input logic [63:0] u, input logic [6:0] f);
        in_valid = v; in_sel = s; in_result = r; in_upper = u; in_flags = f;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        set_in(0, '0, '0, '0, '0);
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
        tick();
        tick();
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst count", count, 0);
        check("rst op_count", op_count, 0);
        check("rst sticky", sticky_flags, 0);
        check("rst out_result", out_result, 0);
        rst_n = 1'b1;
        check_en = 1;

        // Single push, visible after the edge.
        set_in(1, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 7'h10);
        tick();
        set_in(0, '0, '0, '0, '0);
        check("t1 out_valid", out_valid, 1);
        check("t1 out_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t1 count", count, 1);
        check("t1 op_count", op_count, 1);
        check("t1 sticky", sticky_flags, 7'h10);

        // Fill to full, refused fifth push, then ordered drain.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            set_in(1, 6'(i), 64'(i * 3), 64'(i * 7), 7'(i));
            tick();
        end
        check("full count", count, 4);
        check("full in_ready", in_ready, 0);
        set_in(1, 6'd5, 64'd5, 64'd5, 7'd5);
        tick();
        set_in(0, '0, '0, '0, '0);
        check("full op_count", op_count, 4);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain out_sel", out_sel, 64'(i));
            tick();
        end
        check("drained out_valid", out_valid, 0);

        // Streaming push and pop of every legal opcode.
        for (int i = 0; i < 35; i++) begin
            set_in(1, 6'(i), {32'(i), 32'hA5A5_0000}, 64'(~i), 7'(i));
            tick();
            check("stream count", count, 1);
        end
        set_in(0, '0, '0, '0, '0);
        tick();
        check("stream empty", out_valid, 0);

        // Illegal opcode, then clear coinciding with a push.
        set_in(1, 6'd40, 64'h1234, 64'h0, 7'h00);
        tick();
        set_in(0, '0, '0, '0, '0);
        check("illegal out_sel", out_sel, 40);
        check("illegal err", err_illegal_sel, 1);
        sticky_clr = 1'b1;
        set_in(1, 6'd3, 64'h55, 64'h66, 7'h04);
        tick();
        sticky_clr = 1'b0;
        set_in(0, '0, '0, '0, '0);
        check("clr+push sticky", sticky_flags, 7'h04);
        check("clr+push err", err_illegal_sel, 0);
        tick();

        // Asynchronous reset with entries in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 6'(i + 7), 64'(i), 64'(i), 7'(i));
            tick();
        end
        set_in(0, '0, '0, '0, '0);
        check("pre-rst count", count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async out_valid", out_valid, 0);
        check("async count", count, 0);
        check("async in_ready", in_ready, 1);
        check("async op_count", op_count, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Counter wrap from a forced all-ones value.
        force dut.op_count = 32'hFFFF_FFFF;
        preload_opc = 1;
        #1;
        release dut.op_count;
        set_in(1, 6'd2, 64'd9, 64'd9, 7'd0);
        tick();
        preload_opc = 0;
        set_in(0, '0, '0, '0, '0);
        check("wrap op_count", op_count, 0);
        out_ready = 1'b1;
        tick();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            set_in(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                   {$urandom, $urandom}, {$urandom, $urandom}, 7'($urandom));
            out_ready  = ($urandom_range(0, 3) != 0) ? (c % 100 < 70) : 1'b0;
            sticky_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        set_in(0, '0, '0, '0, '0);
        sticky_clr = 1'b0;
        tick();
        check_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
